// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit owning the HI/LO registers.
// One product/quotient bit per cycle, followed by a single sign-fixup cycle.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_rtype,
    input  logic [5:0]      ex_func,
    input  logic            ex_adv,
    input  logic [XLEN-1:0] ex_rs,
    input  logic [XLEN-1:0] ex_rt,
    output logic            md_hold_n,
    output logic [XLEN-1:0] md_rdata,
    output logic            md_busy
);

    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [XLEN-1:0]     hi_q, lo_q;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     op_m;
    logic                op_div, neg_q, neg_r, div_zero;

    logic                md_op, hl_op, issue, is_signed, is_div;
    logic [XLEN-1:0]     rs_mag, rt_mag;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nxt;
    logic [XLEN:0]       div_sh;
    logic                div_ge;
    logic [XLEN-1:0]     div_diff;
    logic [2*XLEN-1:0]   div_nxt;
    logic [2*XLEN-1:0]   mul_res;
    logic [XLEN-1:0]     quo_res, rem_res;

    function automatic logic [XLEN-1:0] mag_x(input logic signed [XLEN-1:0] v, input logic sgn);
        return (sgn && v < 0) ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] cond_neg_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Decode and hold: hold only for HI/LO consumers while an operation is in flight
    assign md_op     = ex_rtype && (ex_func[5:2] == 4'b0110);
    assign hl_op     = ex_rtype && (ex_func[5:2] == 4'b0100);
    assign md_busy   = (state != IDLE);
    assign md_hold_n = ~(md_busy & (md_op | hl_op));
    assign issue     = md_op & ex_adv & md_hold_n;
    assign is_signed = ~ex_func[0];
    assign is_div    = ex_func[1];
    assign rs_mag    = mag_x(ex_rs, is_signed);
    assign rt_mag    = mag_x(ex_rt, is_signed);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (issue) state_nxt = is_div ? DIV : MUL;
            MUL, DIV: if (cnt == CNT_W'(XLEN - 1)) state_nxt = FIX;
            FIX:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= '0;
        end else if (state == MUL || state == DIV) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Iteration step: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_m} : {(XLEN+1){1'b0}});
    assign mul_nxt  = {mul_sum, acc[XLEN-1:1]};
    assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge   = (div_sh >= {1'b0, op_m});
    assign div_diff = div_sh[XLEN-1:0] - op_m;
    assign div_nxt  = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};

    always_ff @(posedge clk) begin
        if (issue) begin
            op_m     <= is_div ? rt_mag : rs_mag;
            acc      <= {{XLEN{1'b0}}, (is_div ? rs_mag : rt_mag)};
            op_div   <= is_div;
            neg_q    <= is_signed & (ex_rs[XLEN-1] ^ ex_rt[XLEN-1]);
            neg_r    <= is_signed & ex_rs[XLEN-1];
            div_zero <= is_div & (ex_rt == '0);
        end else if (state == MUL) begin
            acc <= mul_nxt;
        end else if (state == DIV) begin
            acc <= div_nxt;
        end
    end

    // Fixup: restore signs; divide by zero forces an all-ones quotient
    assign mul_res = cond_neg_2x(acc, neg_q);
    assign quo_res = div_zero ? '1 : cond_neg_x(acc[XLEN-1:0], neg_q);
    assign rem_res = cond_neg_x(acc[2*XLEN-1:XLEN], neg_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == FIX) begin
            hi_q <= op_div ? rem_res : mul_res[2*XLEN-1:XLEN];
            lo_q <= op_div ? quo_res : mul_res[XLEN-1:0];
        end else if (hl_op && ex_adv && md_hold_n) begin
            if (ex_func == F_MTHI) hi_q <= ex_rs;
            if (ex_func == F_MTLO) lo_q <= ex_rs;
        end
    end

    always_comb begin
        md_rdata = '0;
        if (ex_rtype && ex_func == F_MFHI) md_rdata = hi_q;
        else if (ex_rtype && ex_func == F_MFLO) md_rdata = lo_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: a cycle-level arithmetic model predicts
// hold/busy/read data; a negedge monitor compares the DUT against it.
module tb_ex_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_rtype = 1'b0;
    logic [5:0]  ex_func = 6'h0;
    logic        ex_adv = 1'b0;
    logic [31:0] ex_rs = '0, ex_rt = '0;
    logic        md_hold_n, md_busy;
    logic [31:0] md_rdata;

    ex_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .ex_rtype(ex_rtype), .ex_func(ex_func), .ex_adv(ex_adv),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .md_hold_n(md_hold_n), .md_rdata(md_rdata), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hold_n;
        logic        busy;
        logic        chk_rdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_busy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void compute(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                    output logic [31:0] hi, output logic [31:0] lo);
        longint      sp, sq, sr;
        logic [63:0] up;
        hi = '0;
        lo = '0;
        case (f)
            F_MULT: begin
                sp = longint'($signed(rs)) * longint'($signed(rt));
                {hi, lo} = sp;
            end
            F_MULTU: begin
                up = {32'b0, rs} * {32'b0, rt};
                {hi, lo} = up;
            end
            F_DIV: begin
                if (rt == 0) begin
                    hi = rs; lo = '1;
                end else begin
                    sq = longint'($signed(rs)) / longint'($signed(rt));
                    sr = longint'($signed(rs)) % longint'($signed(rt));
                    lo = sq[31:0]; hi = sr[31:0];
                end
            end
            default: begin
                if (rt == 0) begin
                    hi = rs; lo = '1;
                end else begin
                    lo = rs / rt; hi = rs % rt;
                end
            end
        endcase
    endfunction

    function automatic logic is_md(input logic r, input logic [5:0] f);
        return r && (f >= 6'h18) && (f <= 6'h1B);
    endfunction

    function automatic logic is_hl(input logic r, input logic [5:0] f);
        return r && (f >= 6'h10) && (f <= 6'h13);
    endfunction

    function automatic logic pred_hold(input logic r, input logic [5:0] f);
        return !((m_busy > 0) && (is_md(r, f) || is_hl(r, f)));
    endfunction

    // One clock cycle: called just after a rising edge; returns to just after the next one.
    task automatic cycle(input logic r, input logic [5:0] f, input logic adv, input logic [31:0] rs,
                         input logic [31:0] rt, output logic hold_exp, output logic [31:0] rdata_act);
        exp_t e;
        logic md, hl;
        ex_rtype = r; ex_func = f; ex_adv = adv; ex_rs = rs; ex_rt = rt;
        md = is_md(r, f);
        hl = is_hl(r, f);
        e.busy      = (m_busy > 0);
        e.hold_n    = pred_hold(r, f);
        e.chk_rdata = e.hold_n;
        e.rdata     = (r && f == F_MFHI) ? m_hi : (r && f == F_MFLO) ? m_lo : 32'h0;
        sb_q.push_back(e);
        hold_exp = e.hold_n;
        #1 rdata_act = md_rdata;
        @(posedge clk);
        if (reset) begin
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_hi = p_hi; m_lo = p_lo;
                end
            end else if (md && adv && e.hold_n) begin
                compute(f, rs, rt, p_hi, p_lo);
                m_busy = XLEN + 1;
            end
            if (hl && adv && e.hold_n) begin
                if (f == F_MTHI) m_hi = rs;
                if (f == F_MTLO) m_lo = rs;
            end
        end
        #1;
    endtask

    task automatic do_instr(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                            input int stalls, output int held, output logic [31:0] rdata);
        logic h;
        logic adv;
        held = 0;
        repeat (stalls) cycle(1'b1, f, 1'b0, rs, rt, h, rdata);
        for (int i = 0; i < 100; i++) begin
            adv = pred_hold(1'b1, f) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle(1'b1, f, adv, rs, rt, h, rdata);
            if (h) break;
            held++;
            if (i == 99) begin
                checks++; errors++;
                $display("FAIL hold_bound: instruction %h still held after %0d cycles", f, held);
            end
        end
    endtask

    task automatic bubbles(input int n);
        logic        h, r;
        logic [5:0]  f;
        logic [31:0] rd;
        logic [5:0]  others[4] = '{6'h00, 6'h20, 6'h21, 6'h2A};
        for (int i = 0; i < n; i++) begin
            r = 1'($urandom_range(0, 1));
            f = r ? others[$urandom_range(0, 3)] : 6'($urandom);
            cycle(r, f, 1'b1, $urandom, $urandom, h, rd);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("md_hold_n", 64'(md_hold_n), 64'(e.hold_n));
            check("md_busy", 64'(md_busy), 64'(e.busy));
            if (e.chk_rdata) check("md_rdata", 64'(md_rdata), 64'(e.rdata));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          held;
        logic [31:0] rd;
        logic        h;
        logic [5:0]  ops[8] = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};
        logic [31:0] corners[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};
        logic [31:0] a, b;

        // Reset state
        @(posedge clk); #1;
        cycle(1'b1, F_MFHI, 1'b1, 32'h0, 32'h0, h, rd);
        cycle(1'b1, F_MFLO, 1'b1, 32'h0, 32'h0, h, rd);
        reset = 1'b1;
        bubbles(2);

        // Full-width unsigned product, read long after completion
        do_instr(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, held, rd);
        bubbles(40);
        do_instr(F_MFHI, 0, 0, 0, held, rd);
        check("t1_hi", 64'(rd), 64'h0000_0000_FFFF_FFFE);
        check("t1_hi_held", 64'(held), 64'd0);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t1_lo", 64'(rd), 64'h1);

        // Signed multiply read immediately: held for the full latency
        do_instr(F_MULT, 32'hFFFFFFFD, 32'd7, 0, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t2_held", 64'(held), 64'd33);
        check("t2_lo", 64'(rd), 64'hFFFFFFEB);

        // Signed divide and unsigned divide by zero
        do_instr(F_DIV, 32'hFFFFFFF9, 32'd2, 0, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t3_div_lo", 64'(rd), 64'hFFFFFFFD);
        do_instr(F_MFHI, 0, 0, 0, held, rd);
        check("t3_div_hi", 64'(rd), 64'hFFFFFFFF);
        do_instr(F_DIVU, 32'd7, 32'd0, 0, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t3_dz_lo", 64'(rd), 64'hFFFFFFFF);
        do_instr(F_MFHI, 0, 0, 0, held, rd);
        check("t3_dz_hi", 64'(rd), 64'h7);

        // Overflowing signed divide, then back-to-back divides
        do_instr(F_DIV, 32'h80000000, 32'hFFFFFFFF, 0, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t4_ovf_lo", 64'(rd), 64'h80000000);
        do_instr(F_MFHI, 0, 0, 0, held, rd);
        check("t4_ovf_hi", 64'(rd), 64'h0);
        do_instr(F_DIVU, 32'd100, 32'd7, 0, held, rd);
        do_instr(F_DIVU, 32'd1000, 32'd9, 0, held, rd);
        check("t4_b2b_held", 64'(held), 64'd33);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t4_b2b_lat", 64'(held), 64'd33);
        check("t4_b2b_lo", 64'(rd), 64'd111);
        do_instr(F_MFHI, 0, 0, 0, held, rd);
        check("t4_b2b_hi", 64'(rd), 64'd1);

        // External stall before issue; MTLO/MFLO round trip
        do_instr(F_MULT, 32'd5, 32'd6, 3, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t5_mult_lo", 64'(rd), 64'd30);
        do_instr(F_MTLO, 32'h1234, 0, 1, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t5_mtlo", 64'(rd), 64'h1234);
        check("t5_mtlo_held", 64'(held), 64'd0);

        // Asynchronous reset in the middle of a divide
        do_instr(F_DIV, 32'd100, 32'd3, 0, held, rd);
        bubbles(9);
        ex_rtype = 1'b1; ex_func = F_MFHI; ex_adv = 1'b1;
        reset = 1'b0;
        #1;
        check("t6_busy", 64'(md_busy), 64'd0);
        check("t6_hold_n", 64'(md_hold_n), 64'd1);
        check("t6_hi", 64'(md_rdata), 64'd0);
        m_hi = '0; m_lo = '0; m_busy = 0;
        cycle(1'b1, F_MFLO, 1'b1, 0, 0, h, rd);
        check("t6_lo", 64'(rd), 64'd0);
        reset = 1'b1;
        bubbles(1);
        do_instr(F_MULT, 32'd2, 32'd3, 0, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);
        check("t6_mult_held", 64'(held), 64'd33);
        check("t6_mult_lo", 64'(rd), 64'd6);

        // Randomised instruction mix with corner operands
        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            do_instr(ops[$urandom_range(0, 7)], a, b, $urandom_range(0, 2), held, rd);
            bubbles($urandom_range(0, 40));
        end
        do_instr(F_MFHI, 0, 0, 0, held, rd);
        do_instr(F_MFLO, 0, 0, 0, held, rd);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
